// File: rtl/quad_pkg.sv
// Shared phase encodings, direction constants and the forward phase
// successor used by the quadrature decoder.
package quad_pkg;

    typedef logic [1:0] phase_t;

    // {A,B} phase encodings
    localparam phase_t PH_00 = 2'b00;
    localparam phase_t PH_10 = 2'b10;
    localparam phase_t PH_11 = 2'b11;
    localparam phase_t PH_01 = 2'b01;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Width of the stability counter; covers FILT up to 15
    localparam int CNT_W = 4;

    // Forward (count-up) successor: 00 -> 10 -> 11 -> 01 -> 00
    function automatic phase_t phase_succ(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-flop synchronizer plus stability filter for the {A,B} pair.
// A new value is accepted once it has been held for FILT sampled
// cycles. The first accepted value after reset only primes q; later
// acceptances raise acc for one cycle with q (old) and q_new (new).
module quad_sync_filter
    import quad_pkg::*;
#(
    parameter int FILT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] din,
    output logic [1:0] q,
    output logic [1:0] q_new,
    output logic       acc
);

    localparam logic [CNT_W-1:0] FILT_C = CNT_W'(FILT);

    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       hold_p2;
    logic             vld_p0;
    logic             vld_p1;
    logic             vld_p2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             primed;
    logic             target;
    logic             stable;
    logic             accept;

    // Saturating increment keeps the counter from wrapping on long holds
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0/p1: metastability flops; p2: one-cycle-old copy of s2.
    // vld_pN marks stages that hold a real sample since reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_p0 <= 2'b00;
            sync_p1 <= 2'b00;
            hold_p2 <= 2'b00;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            hold_p2 <= sync_p1;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
        end
    end

    // Count how many sampled cycles s2 has held a value worth accepting
    always_comb begin
        stable  = vld_p2 && (sync_p1 == hold_p2);
        target  = vld_p1 && (!primed || (sync_p1 != q));
        cnt_nxt = '0;
        if (target) begin
            cnt_nxt = stable ? sat_inc(cnt) : CNT_W'(1);
        end
        accept = target && (cnt_nxt >= FILT_C);
    end

    // Accepted state, counter and priming flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q      <= PH_00;
            cnt    <= '0;
            primed <= 1'b0;
        end else begin
            cnt <= accept ? '0 : cnt_nxt;
            if (accept) begin
                q      <= sync_p1;
                primed <= 1'b1;
            end
        end
    end

    assign q_new = sync_p1;
    assign acc   = accept && primed;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder top: filtered A/B phases are decoded into up/down
// steps, a wrapping position count, last direction and a sticky flag
// for illegal two-bit phase jumps.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int FILT  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic [WIDTH-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             err
);

    phase_t q;
    phase_t q_new;
    logic   acc;
    logic   fwd;
    logic   rev;
    logic   jump;

    quad_sync_filter #(
        .FILT (FILT)
    ) u_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({a_in, b_in}),
        .q       (q),
        .q_new   (q_new),
        .acc     (acc)
    );

    // Classify an accepted transition as forward, reverse or illegal jump
    always_comb begin
        fwd  = acc && (q_new == phase_succ(q));
        rev  = acc && (q == phase_succ(q_new));
        jump = acc && (q_new == ~q);
    end

    // Position, direction, step pulse and sticky error; clr wins over a step
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos  <= '0;
            dir  <= DIR_DOWN;
            step <= 1'b0;
            err  <= 1'b0;
        end else begin
            step <= fwd || rev;
            if (fwd) begin
                pos <= pos + WIDTH'(1);
                dir <= DIR_UP;
            end else if (rev) begin
                pos <= pos - WIDTH'(1);
                dir <= DIR_DOWN;
            end
            if (jump) begin
                err <= 1'b1;
            end
            if (clr) begin
                pos <= '0;
                err <= 1'b0;
            end
        end
    end

endmodule
